// File: rtl/counter_cycle_arbiter.sv
// counter_cycle_arbiter
// Steals RAM cycles from the core to apply involuntary +1/-1 counter updates.
// Each steal is a two-cycle read-modify-write (READ, WRITE) that holds the
// core stalled. At least one IDLE cycle always separates consecutive steals,
// so the core keeps making progress. The update uses 15-bit ones' complement
// arithmetic.
module counter_cycle_arbiter #(
    parameter int unsigned NUM_CTR   = 8,
    parameter logic [14:0] BASE_ADDR = 15'o24
) (
    input  logic               clock,
    input  logic               rst_l,
    input  logic [NUM_CTR-1:0] inc_req,
    input  logic [NUM_CTR-1:0] dec_req,
    input  logic [14:0]        core_raddr,
    input  logic [14:0]        core_waddr,
    input  logic [14:0]        core_wdata,
    input  logic               core_we,
    input  logic [14:0]        ram_read_data,
    output logic [14:0]        ram_read_address,
    output logic [14:0]        ram_write_address,
    output logic [14:0]        ram_write_data,
    output logic               ram_write_en,
    output logic               stall_core,
    output logic [NUM_CTR-1:0] ovf_pulse,
    output logic [NUM_CTR-1:0] overrun
);

    localparam int unsigned SEL_W = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_CTR-1:0] pend_inc_q, pend_inc_d;
    logic [NUM_CTR-1:0] pend_dec_q, pend_dec_d;
    logic [NUM_CTR-1:0] overrun_q, overrun_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               dir_inc_q, dir_inc_d;

    logic               any_pend;
    logic               launch;
    logic [SEL_W-1:0]   pick;
    logic [14:0]        ctr_addr;
    logic [15:0]        sum;
    logic [14:0]        res;
    logic               res_ovf;

    // Priority encoder: lowest pending index wins.
    always_comb begin
        any_pend = 1'b0;
        pick     = '0;
        for (int i = int'(NUM_CTR) - 1; i >= 0; i--) begin
            if (pend_inc_q[i] | pend_dec_q[i]) begin
                any_pend = 1'b1;
                pick     = SEL_W'(i);
            end
        end
    end

    assign launch   = (state_q == IDLE) && any_pend;
    assign ctr_addr = BASE_ADDR + 15'(sel_q);

    // Next-state logic for the steal sequencer.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dir_inc_d = dir_inc_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d   = READ;
                    sel_d     = pick;
                    dir_inc_d = pend_inc_q[pick];
                end
            end
            READ:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pending latch. The launched counter is cleared first, so a request that
    // arrives on its launch edge becomes a fresh pending entry.
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        pend_inc_d = pend_inc_q;
        pend_dec_d = pend_dec_q;
        overrun_d  = overrun_q;
        if (launch) begin
            pend_inc_d[pick] = 1'b0;
            pend_dec_d[pick] = 1'b0;
        end
        for (int i = 0; i < int'(NUM_CTR); i++) begin
            if (inc_req[i] && dec_req[i]) begin
                // Opposite requests in the same cycle cancel each other.
            end else if (inc_req[i]) begin
                if (pend_dec_d[i])      pend_dec_d[i] = 1'b0;
                else if (pend_inc_d[i]) overrun_d[i]  = 1'b1;
                else                    pend_inc_d[i] = 1'b1;
            end else if (dec_req[i]) begin
                if (pend_inc_d[i])      pend_inc_d[i] = 1'b0;
                else if (pend_dec_d[i]) overrun_d[i]  = 1'b1;
                else                    pend_dec_d[i] = 1'b1;
            end
        end
    end

    // Ones'-complement +1 / -1 with end-around carry on the RAM read data.
    always_comb begin
        sum     = '0;
        res     = '0;
        res_ovf = 1'b0;
        if (dir_inc_q) begin
            if (ram_read_data == 15'o37777) begin
                res_ovf = 1'b1;
            end else begin
                sum = {1'b0, ram_read_data} + 16'd1;
                res = sum[14:0] + {14'd0, sum[15]};
            end
        end else begin
            if (ram_read_data == 15'o40000) begin
                res     = 15'o77777;
                res_ovf = 1'b1;
            end else begin
                sum = {1'b0, ram_read_data} + 16'o077776;
                res = sum[14:0] + {14'd0, sum[15]};
            end
        end
    end

    // RAM port mux and stall. The core owns the port in IDLE; otherwise the
    // arbiter owns it and the core write is blocked.
    always_comb begin
        ram_read_address  = core_raddr;
        ram_write_address = core_waddr;
        ram_write_data    = core_wdata;
        ram_write_en      = core_we;
        stall_core        = 1'b0;
        ovf_pulse         = '0;
        case (state_q)
            READ: begin
                stall_core       = 1'b1;
                ram_read_address = ctr_addr;
                ram_write_en     = 1'b0;
            end
            WRITE: begin
                stall_core        = 1'b1;
                ram_write_address = ctr_addr;
                ram_write_data    = res;
                ram_write_en      = 1'b1;
                ovf_pulse[sel_q]  = res_ovf;
            end
            default: ;
        endcase
    end

    assign overrun = overrun_q;

    // State registers. An asynchronous reset abandons any in-flight steal.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            pend_inc_q <= '0;
            pend_dec_q <= '0;
            overrun_q  <= '0;
            sel_q      <= '0;
            dir_inc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_inc_q <= pend_inc_d;
            pend_dec_q <= pend_dec_d;
            overrun_q  <= overrun_d;
            sel_q      <= sel_d;
            dir_inc_q  <= dir_inc_d;
        end
    end

endmodule

// File: tb/tb_counter_cycle_arbiter.sv
// Directed testbench for counter_cycle_arbiter with a behavioural RAM that
// reads synchronously (one-cycle latency).
module tb_counter_cycle_arbiter;

    logic        clock;
    logic        rst_l;
    logic [7:0]  inc_req, dec_req;
    logic [14:0] core_raddr, core_waddr, core_wdata;
    logic        core_we;
    logic [14:0] ram_read_data;
    logic [14:0] ram_read_address, ram_write_address, ram_write_data;
    logic        ram_write_en, stall_core;
    logic [7:0]  ovf_pulse, overrun;

    int checks = 0;
    int errors = 0;

    // RAM model plus a back-door load port used only while the DUT is idle.
    logic [14:0] mem [0:32767];
    logic        load_en;
    logic [14:0] load_addr, load_data;
    int          wr_cnt = 0;
    int          stall_cnt = 0;

    counter_cycle_arbiter #(.NUM_CTR(8), .BASE_ADDR(15'o24)) dut (
        .clock(clock), .rst_l(rst_l),
        .inc_req(inc_req), .dec_req(dec_req),
        .core_raddr(core_raddr), .core_waddr(core_waddr),
        .core_wdata(core_wdata), .core_we(core_we),
        .ram_read_data(ram_read_data),
        .ram_read_address(ram_read_address),
        .ram_write_address(ram_write_address),
        .ram_write_data(ram_write_data),
        .ram_write_en(ram_write_en), .stall_core(stall_core),
        .ovf_pulse(ovf_pulse), .overrun(overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (ram_write_en) mem[ram_write_address] <= ram_write_data;
        ram_read_data <= mem[ram_read_address];
        if (ram_write_en && !load_en) wr_cnt <= wr_cnt + 1;
        if (stall_core) stall_cnt <= stall_cnt + 1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [14:0] a, input logic [14:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_l = 1'b0;
        inc_req = '0; dec_req = '0;
        core_raddr = '0; core_waddr = '0; core_wdata = '0; core_we = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        tick(); tick();
        checks++; if (stall_core !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_core); end
        checks++; if (ram_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", ram_write_en); end
        checks++; if (ovf_pulse !== 8'h00) begin errors++; $display("FAIL reset_ovf: got %h want 00", ovf_pulse); end
        checks++; if (overrun !== 8'h00) begin errors++; $display("FAIL reset_overrun: got %h want 00", overrun); end
        rst_l = 1'b1;
        tick();
    endtask

    // Scenario 1: single +1 on counter 3, cycle-by-cycle.
    task automatic test_single_inc;
        int s0;
        load(15'o27, 15'o00005);
        s0 = stall_cnt;
        inc_req = 8'h08;
        tick();
        inc_req = '0;
        checks++; if (stall_core !== 1'b0) begin errors++; $display("FAIL t1_latch_stall: got %b want 0", stall_core); end
        tick();
        checks++; if (stall_core !== 1'b1) begin errors++; $display("FAIL t1_read_stall: got %b want 1", stall_core); end
        checks++; if (ram_read_address !== 15'o27) begin errors++; $display("FAIL t1_read_addr: got %o want 27", ram_read_address); end
        checks++; if (ram_write_en !== 1'b0) begin errors++; $display("FAIL t1_read_we: got %b want 0", ram_write_en); end
        tick();
        checks++; if (stall_core !== 1'b1) begin errors++; $display("FAIL t1_write_stall: got %b want 1", stall_core); end
        checks++; if (ram_write_en !== 1'b1 || ram_write_address !== 15'o27 || ram_write_data !== 15'o6)
            begin errors++; $display("FAIL t1_write_port: got we=%b a=%o d=%o want we=1 a=27 d=6", ram_write_en, ram_write_address, ram_write_data); end
        checks++; if (ovf_pulse !== 8'h00) begin errors++; $display("FAIL t1_ovf: got %h want 00", ovf_pulse); end
        tick();
        checks++; if (stall_core !== 1'b0) begin errors++; $display("FAIL t1_idle_stall: got %b want 0", stall_core); end
        checks++; if (mem[15'o27] !== 15'o00006) begin errors++; $display("FAIL t1_ram: got %o want 00006", mem[15'o27]); end
        tick();
        checks++; if (stall_cnt - s0 !== 2) begin errors++; $display("FAIL t1_stall_cycles: got %0d want 2", stall_cnt - s0); end
    endtask

    // Scenario 2: arithmetic boundaries, including overflow and -0 handling.
    task automatic test_arith;
        logic [2:0]  idx  [5] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6};
        logic        up   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [14:0] init [5] = '{15'o37777, 15'o40000, 15'o77777, 15'o00000, 15'o00005};
        logic [14:0] expv [5] = '{15'o00000, 15'o77777, 15'o00001, 15'o77776, 15'o00004};
        logic        eovf [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            logic [14:0] a;
            logic [7:0]  ov;
            a  = 15'o24 + 15'(idx[k]);
            ov = eovf[k] ? (8'h01 << idx[k]) : 8'h00;
            load(a, init[k]);
            if (up[k]) inc_req = 8'h01 << idx[k];
            else       dec_req = 8'h01 << idx[k];
            tick();
            inc_req = '0; dec_req = '0;
            tick(); tick();
            checks++; if (ovf_pulse !== ov) begin errors++; $display("FAIL t2_ovf[%0d]: got %h want %h", k, ovf_pulse, ov); end
            tick();
            checks++; if (ovf_pulse !== 8'h00) begin errors++; $display("FAIL t2_ovf_len[%0d]: got %h want 00", k, ovf_pulse); end
            checks++; if (mem[a] !== expv[k]) begin errors++; $display("FAIL t2_ram[%0d]: got %o want %o", k, mem[a], expv[k]); end
        end
    endtask

    // Scenario 3: simultaneous requests; priority and the mandatory IDLE gap.
    task automatic test_back_to_back;
        logic [0:5] exp_stall = 6'b110110;
        load(15'o26, 15'o00010);
        load(15'o31, 15'o00020);
        inc_req = 8'h24;
        tick();
        inc_req = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (stall_core !== exp_stall[c]) begin errors++; $display("FAIL t3_stall[%0d]: got %b want %b", c, stall_core, exp_stall[c]); end
            if (c == 0) begin
                checks++; if (ram_read_address !== 15'o26) begin errors++; $display("FAIL t3_first_addr: got %o want 26", ram_read_address); end
            end
            if (c == 3) begin
                checks++; if (ram_read_address !== 15'o31) begin errors++; $display("FAIL t3_second_addr: got %o want 31", ram_read_address); end
            end
        end
        checks++; if (mem[15'o26] !== 15'o00011) begin errors++; $display("FAIL t3_ram2: got %o want 00011", mem[15'o26]); end
        checks++; if (mem[15'o31] !== 15'o00021) begin errors++; $display("FAIL t3_ram5: got %o want 00021", mem[15'o31]); end
    endtask

    // Scenario 4: cancel and overrun on counter 4 while counter 0 is in flight.
    task automatic test_cancel_overrun;
        int w0, s0;
        load(15'o24, 15'o00100);
        load(15'o30, 15'o00050);
        w0 = wr_cnt; s0 = stall_cnt;
        inc_req = 8'h01; tick();
        inc_req = 8'h10; tick();
        inc_req = 8'h00; dec_req = 8'h10; tick();
        dec_req = 8'h00;
        for (int c = 0; c < 5; c++) tick();
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL t4_cancel_writes: got %0d want 1", wr_cnt - w0); end
        checks++; if (stall_cnt - s0 !== 2) begin errors++; $display("FAIL t4_cancel_stall: got %0d want 2", stall_cnt - s0); end
        checks++; if (mem[15'o30] !== 15'o00050) begin errors++; $display("FAIL t4_cancel_ram: got %o want 00050", mem[15'o30]); end
        checks++; if (overrun !== 8'h00) begin errors++; $display("FAIL t4_no_overrun: got %h want 00", overrun); end

        w0 = wr_cnt;
        inc_req = 8'h01; tick();
        inc_req = 8'h10; tick();
        inc_req = 8'h10; tick();
        inc_req = 8'h00;
        checks++; if (overrun !== 8'h10) begin errors++; $display("FAIL t4_overrun: got %h want 10", overrun); end
        for (int c = 0; c < 6; c++) tick();
        checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL t4_ovr_writes: got %0d want 2", wr_cnt - w0); end
        checks++; if (mem[15'o30] !== 15'o00051) begin errors++; $display("FAIL t4_ovr_ram: got %o want 00051", mem[15'o30]); end
    endtask

    // Scenario 5: reset asserted mid-WRITE with counter 7 still pending.
    task automatic test_reset_in_write;
        int w0;
        load(15'o27, 15'o00123);
        load(15'o33, 15'o00200);
        w0 = wr_cnt;
        inc_req = 8'h88; tick();
        inc_req = 8'h00;
        tick(); tick();
        checks++; if (ram_write_en !== 1'b1) begin errors++; $display("FAIL t5_in_write: got %b want 1", ram_write_en); end
        #2 rst_l = 1'b0;
        #1;
        checks++; if (ram_write_en !== 1'b0) begin errors++; $display("FAIL t5_we_drop: got %b want 0", ram_write_en); end
        checks++; if (stall_core !== 1'b0) begin errors++; $display("FAIL t5_stall_drop: got %b want 0", stall_core); end
        tick(); tick();
        rst_l = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (stall_core !== 1'b0) begin errors++; $display("FAIL t5_post_stall[%0d]: got %b want 0", c, stall_core); end
        end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL t5_writes: got %0d want 0", wr_cnt - w0); end
        checks++; if (mem[15'o27] !== 15'o00123) begin errors++; $display("FAIL t5_ram3: got %o want 00123", mem[15'o27]); end
        checks++; if (mem[15'o33] !== 15'o00200) begin errors++; $display("FAIL t5_ram7: got %o want 00200", mem[15'o33]); end
        checks++; if (overrun !== 8'h00) begin errors++; $display("FAIL t5_overrun: got %h want 00", overrun); end
    endtask

    // Scenario 6: core pass-through in IDLE, core write blocked in READ.
    task automatic test_core_passthrough;
        load(15'o1001, 15'o00111);
        core_raddr = 15'o2222; core_waddr = 15'o1000; core_wdata = 15'o12345; core_we = 1'b1;
        #1;
        checks++; if (ram_read_address !== 15'o2222) begin errors++; $display("FAIL t6_raddr: got %o want 2222", ram_read_address); end
        checks++; if (ram_write_en !== 1'b1 || ram_write_address !== 15'o1000 || ram_write_data !== 15'o12345)
            begin errors++; $display("FAIL t6_wport: got we=%b a=%o d=%o want we=1 a=1000 d=12345", ram_write_en, ram_write_address, ram_write_data); end
        tick();
        core_we = 1'b0;
        checks++; if (mem[15'o1000] !== 15'o12345) begin errors++; $display("FAIL t6_ram: got %o want 12345", mem[15'o1000]); end
        inc_req = 8'h40; tick();
        inc_req = 8'h00; tick();
        core_waddr = 15'o1001; core_wdata = 15'o00777; core_we = 1'b1;
        #1;
        checks++; if (ram_write_en !== 1'b0) begin errors++; $display("FAIL t6_read_block: got %b want 0", ram_write_en); end
        tick();
        core_we = 1'b0;
        tick(); tick();
        checks++; if (mem[15'o1001] !== 15'o00111) begin errors++; $display("FAIL t6_blocked_ram: got %o want 00111", mem[15'o1001]); end
        checks++; if (mem[15'o32] !== 15'o00005) begin errors++; $display("FAIL t6_ctr6: got %o want 00005", mem[15'o32]); end
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_arith();
        test_back_to_back();
        test_cancel_overrun();
        test_reset_in_write();
        test_core_passthrough();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
